// File: rtl/pmem_if.sv
// 128-bit cache-line memory bus between an L2/write-buffer initiator and memory.
interface pmem_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency cache-line memory responder: accepts one line read/write,
// waits LATENCY cycles, pulses pmem_resp, and keeps usage counters plus a
// sticky protocol-error flag.
module pmem_responder #(
  parameter int LATENCY   = 10,
  parameter int LINE_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  pmem_if.slave       pmem,
  output logic        busy,
  output logic        proto_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int         LINES  = 1 << LINE_BITS;
  // WAIT counts down to zero, so it starts two below the total latency.
  localparam logic [7:0] CNT_INIT = 8'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  logic [1:0]           state_reg, state_next;
  logic [7:0]           cnt_reg, cnt_next;
  logic [LINE_BITS-1:0] idx_reg;
  logic [127:0]         wdata_reg;
  logic                 op_wr_reg;
  logic                 busy_reg;
  logic                 proto_reg;
  logic [15:0]          rd_cnt_reg, wr_cnt_reg;
  logic [127:0]         rdata_reg;
  logic [127:0]         line_mem [LINES];

  logic                 req;
  logic [LINE_BITS-1:0] addr_idx;
  logic [LINE_BITS-1:0] rd_idx;
  logic                 rd_op;
  logic                 enter_resp;
  logic                 unused_addr;

  assign req         = pmem.pmem_read | pmem.pmem_write;
  assign addr_idx    = pmem.pmem_address[LINE_BITS+3:4];
  // Upper address bits alias and the low nibble is the byte offset within the line.
  assign unused_addr = ^pmem.pmem_address;

  // Next-state and latency countdown.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_reg == 8'd0) state_next = S_RESP;
        else                 cnt_next   = cnt_reg - 8'd1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With LATENCY==1 RESP is entered straight from IDLE, so the read index and
  // op must come from the live request rather than the latched copies.
  always_comb begin
    rd_idx     = (state_reg == S_IDLE) ? addr_idx : idx_reg;
    rd_op      = (state_reg == S_IDLE) ? !pmem.pmem_write : !op_wr_reg;
    enter_resp = (state_next == S_RESP) && (state_reg != S_RESP);
  end

  // Control state, request latching, counters and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 8'd0;
      idx_reg    <= '0;
      wdata_reg  <= '0;
      op_wr_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      proto_reg  <= 1'b0;
      rd_cnt_reg <= 16'd0;
      wr_cnt_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next != S_IDLE);
      if (state_reg == S_IDLE && req) begin
        idx_reg   <= addr_idx;
        wdata_reg <= pmem.pmem_wdata;
        op_wr_reg <= pmem.pmem_write;
        if (pmem.pmem_read && pmem.pmem_write) proto_reg <= 1'b1;
      end
      if (state_reg == S_RESP) begin
        if (op_wr_reg) begin
          if (wr_cnt_reg != 16'hFFFF) wr_cnt_reg <= wr_cnt_reg + 16'd1;
        end else begin
          if (rd_cnt_reg != 16'hFFFF) rd_cnt_reg <= rd_cnt_reg + 16'd1;
        end
      end
    end
  end

  // Line array write port: commit on the RESP exit edge, suppressed by reset.
  always_ff @(posedge clk) begin
    if (!reset && state_reg == S_RESP && op_wr_reg) line_mem[idx_reg] <= wdata_reg;
  end

  // Registered read port, loaded on RESP entry and held until the next read.
  always_ff @(posedge clk) begin
    if (reset)                    rdata_reg <= '0;
    else if (enter_resp && rd_op) rdata_reg <= line_mem[rd_idx];
  end

  assign pmem.pmem_resp  = (state_reg == S_RESP);
  assign pmem.pmem_rdata = rdata_reg;
  assign busy            = busy_reg;
  assign proto_err       = proto_reg;
  assign rd_count        = rd_cnt_reg;
  assign wr_count        = wr_cnt_reg;

endmodule
